// File: rtl/tick_checker.sv
// tick_checker: measures tick-to-tick periods, flags early/missing ticks and declares lock.
// Define TICK_CHECK_HIST_EN to add min_period/max_period tracking.
module tick_checker #(
  parameter int NOMINAL = 50000001,
  parameter int TOL = 1000,
  parameter int LOCK_N = 4,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             tick,
  input  logic             clear_err,
  output logic             locked,
  output logic             early_err,
  output logic             late_err,
  output logic [7:0]       miss_cnt,
  output logic [CNT_W-1:0] last_period,
  output logic             period_valid
`ifdef TICK_CHECK_HIST_EN
  ,
  output logic [CNT_W-1:0] min_period,
  output logic [CNT_W-1:0] max_period
`endif
);
  localparam int GW = $clog2(LOCK_N + 1);
  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK} state_t;
  state_t state, state_nx;
  logic tick_d, rise, early, timeout, pv;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [GW-1:0] good_run, good_nx;
  assign rise = tick & ~tick_d;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    good_nx = good_run;
    early = 1'b0;
    timeout = 1'b0;
    pv = 1'b0;
    if (!enable) begin
      state_nx = IDLE;
      cnt_nx = '0;
      good_nx = '0;
    end else if (state == IDLE) begin
      state_nx = ACQUIRE;
      cnt_nx = '0;
    end else if (state == ACQUIRE) begin
      state_nx = rise ? TRACK : ACQUIRE;
      cnt_nx = rise ? CNT_W'(1) : cnt;
    end else if (rise) begin
      pv = 1'b1;
      cnt_nx = CNT_W'(1);
      early = cnt < CNT_W'(NOMINAL - TOL);
      good_nx = early ? '0 : (good_run == GW'(LOCK_N)) ? good_run : good_run + GW'(1);
    end else if (cnt == CNT_W'(NOMINAL + TOL)) begin
      timeout = 1'b1;
      cnt_nx = CNT_W'(1);
      good_nx = '0;
    end else begin
      cnt_nx = cnt + CNT_W'(1);
    end
  end
  // tick_d resets high so a tick already asserted out of reset is not an edge
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      good_run <= '0;
      tick_d <= 1'b1;
      locked <= 1'b0;
      early_err <= 1'b0;
      late_err <= 1'b0;
      miss_cnt <= '0;
      last_period <= '0;
      period_valid <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      good_run <= good_nx;
      tick_d <= tick;
      locked <= good_nx == GW'(LOCK_N);
      early_err <= early | (early_err & ~clear_err);
      late_err <= timeout | (late_err & ~clear_err);
      miss_cnt <= timeout ? (clear_err ? 8'd1 : miss_cnt + {7'd0, miss_cnt != 8'hff})
                          : (clear_err ? 8'd0 : miss_cnt);
      period_valid <= pv;
      if (pv) last_period <= cnt;
    end
`ifdef TICK_CHECK_HIST_EN
  logic loaded;
  // a new period in the same cycle as clear_err starts a fresh min/max history
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      loaded <= 1'b0;
      min_period <= '0;
      max_period <= '0;
    end else if (pv) begin
      loaded <= 1'b1;
      min_period <= (!loaded || clear_err || cnt < min_period) ? cnt : min_period;
      max_period <= (!loaded || clear_err || cnt > max_period) ? cnt : max_period;
    end else if (clear_err) begin
      loaded <= 1'b0;
      min_period <= '0;
      max_period <= '0;
    end
`endif
endmodule

// File: doc/tick_checker.md
Name: tick_checker

Overview:
- Receiving end of the tick interface driven by the one-second pulse generator.
- Measures the cycle count between consecutive tick pulses and checks it against a nominal period with tolerance.
- Flags early and missing ticks and declares lock after a run of good periods.
- Feeds status LEDs and seven-segment debug displays in the lab top level.

Parameters:
NOMINAL, 50000001, expected cycles between tick rising edges
TOL, 1000, allowed deviation in cycles; good window is NOMINAL-TOL .. NOMINAL+TOL inclusive
LOCK_N, 4, consecutive good periods required to assert locked
CNT_W, 32, width of period counter and last_period; must hold NOMINAL+TOL+1

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
enable  input  1  checking enabled when high
tick  input  1  tick pulse from the divider, synchronous to clock
clear_err  input  1  one-cycle request to clear early_err, late_err and miss_cnt
locked  output  1  high while good_run == LOCK_N
early_err  output  1  sticky: a period shorter than NOMINAL-TOL was seen
late_err  output  1  sticky: a tick timeout occurred
miss_cnt  output  8  saturating count of timeouts (stops at 255)
last_period  output  CNT_W  most recently measured period
period_valid  output  1  one-cycle strobe when last_period updates

Behaviour:
- Reset (reset=0, async): all outputs 0; state IDLE; cnt=0; good_run=0; tick_d=1.
- tick_d=1 at reset means a tick held high out of reset is not counted.
- Edge detect: rise = tick & ~tick_d; tick_d registers tick every cycle.
  - A tick high for several cycles counts as one event.
- Registered outputs: every output change is visible the cycle after the triggering rise or timeout.
- IDLE:
  - cnt=0; rises ignored.
  - enable=1 -> ACQUIRE.
- ACQUIRE:
  - Waits for the first rise; no timeout.
  - On rise: cnt<=1 -> TRACK.
  - last_period is not updated and period_valid is not pulsed.
- TRACK: cnt increments every cycle; at a rise, cnt equals the cycle distance to the previous rise.
  - On rise: last_period<=cnt; period_valid<=1; cnt<=1.
    - cnt < NOMINAL-TOL: early_err<=1, good_run<=0.
    - Otherwise: good_run<=min(good_run+1, LOCK_N).
  - Timeout, when cnt == NOMINAL+TOL and there is no rise this cycle:
    - late_err<=1; miss_cnt<=sat(miss_cnt+1); good_run<=0; cnt<=1.
    - A missing tick restarts the window; repeated silence produces one miss per NOMINAL+TOL cycles.
    - last_period and period_valid are unchanged.
  - A rise on the timeout cycle is an in-window good period.
- locked = (good_run == LOCK_N), registered; it drops the cycle after any error event.
- enable=0 in any state:
  - Next state is IDLE; cnt<=0; good_run<=0; locked<=0.
  - Sticky errors, miss_cnt and last_period are retained.
- clear_err:
  - Clears early_err, late_err and miss_cnt.
  - If an error event occurs in the same cycle, the new error wins: flag set, miss_cnt=1 for a timeout.
- cnt never wraps: it is bounded by the timeout.

Optional Feature:
TICK_CHECK_HIST_EN
- Defined: adds outputs min_period and max_period (CNT_W each).
  - Both reset to 0; the first valid period loads both.
  - Each later period_valid updates min/max; clear_err clears them back to the unloaded state.
- Undefined: the ports and registers do not exist; all other behaviour is identical.

Test Plan:
All scenarios use NOMINAL=10, TOL=1, LOCK_N=3.
1. enable=1; rises every 10 cycles, 5 rises -> period_valid x4, last_period=10; locked=1 the cycle after the 4th rise; no errors.
2. While locked, next rise 8 cycles after the previous -> last_period=8, early_err=1, locked=0 next cycle.
3. Silence for 33 cycles after a rise -> late_err=1; miss_cnt=1 at cnt=11, then 2, then 3; period_valid never pulses.
4. clear_err on the same cycle as a short-period rise -> early_err stays 1; clear_err alone next cycle -> early_err=0, miss_cnt=0.
5. tick held high for 5 cycles, then low, then 1 cycle high 10 cycles after the first edge -> exactly one period, last_period=10.
6. Locked, then reset=0 asynchronously mid-period -> all outputs 0 before the next clock edge; after release with tick high, no rise is counted until tick goes low.
